// File: rtl/gen_gamma_stream_decoder_pkg.sv
// Shared types and width helpers for the generalised-gamma stream decoder.
package gen_gamma_pkg;

    localparam int unsigned GG_DATA_W = 8;
    localparam int unsigned GG_K_MAX  = 3;
    localparam int unsigned GG_KW     = $clog2(GG_K_MAX + 1);
    localparam int unsigned GG_LW     = $clog2(2 * GG_DATA_W + 2);
    localparam int unsigned GG_ZW     = $clog2(GG_DATA_W + 2);

    typedef enum logic {
        PREFIX = 1'b0,
        SUFFIX = 1'b1
    } state_t;

    // Longest legal run of leading zeros for order k.
    function automatic int unsigned max_prefix(input int unsigned data_w, input int unsigned k);
        return data_w - k;
    endfunction

endpackage

// File: rtl/gen_gamma_stream_decoder_if.sv
// Bit-in / value-out handshake bundle of the generalised-gamma decoder.
interface gen_gamma_stream_decoder_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LW     = 5
);
    logic              in_bit;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W:0]   out_data;
    logic [LW-1:0]     out_len;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_bit, in_valid, out_ready,
        input  in_ready, out_data, out_len, out_valid
    );

    modport slave (
        input  in_bit, in_valid, out_ready,
        output in_ready, out_data, out_len, out_valid
    );
endinterface

// File: rtl/gen_gamma_stream_decoder_reg.sv
// W-bit load-enable register with asynchronous active-low clear.
module gen_gamma_stream_decoder_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         res_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n)  q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/gen_gamma_stream_decoder_sub.sv
// Plain W-bit subtractor.
module gen_gamma_stream_decoder_sub #(
    parameter int unsigned W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = a - b;
endmodule

// File: rtl/gen_gamma_stream_decoder.sv
// Streaming Exp-Golomb (order k) decoder: one bit in per cycle, one value out per codeword.
module gen_gamma_stream_decoder
    import gen_gamma_pkg::*;
#(
    parameter int unsigned DATA_W = GG_DATA_W,
    parameter int unsigned K_MAX  = GG_K_MAX,
    parameter int unsigned KW     = $clog2(K_MAX + 1),
    parameter int unsigned LW     = $clog2(2 * DATA_W + 2)
) (
    input  logic                          clk,
    input  logic                          res_n,
    input  logic                          flush,
    input  logic [KW-1:0]                 k_sel,
    gen_gamma_stream_decoder_if.slave     bus,
    output logic                          err
);
    localparam int unsigned ZW = $clog2(DATA_W + 2);
    localparam int unsigned AW = DATA_W + 1;

    state_t         state, state_nxt;
    logic [ZW-1:0]  zcnt, zcnt_nxt;
    logic [ZW-1:0]  rem, rem_nxt;
    logic [AW-1:0]  acc, acc_nxt;
    logic [KW-1:0]  k_q, k_eff;
    logic           accept, first, done, ovf;
    logic [AW-1:0]  one_k, diff;
    logic [LW-1:0]  len_nxt;
    logic [AW+LW-1:0] payload_q;
    logic           valid_nxt;

    assign bus.in_ready = !(bus.out_valid && !bus.out_ready) && !flush;
    assign accept       = bus.in_valid && bus.in_ready;
    assign first        = (state == PREFIX) && (zcnt == '0);
    // k_sel is only honoured on the opening bit; afterwards the latched copy rules.
    assign k_eff        = first ? k_sel : k_q;

    always_comb begin
        state_nxt = state;
        zcnt_nxt  = zcnt;
        rem_nxt   = rem;
        acc_nxt   = acc;
        done      = 1'b0;
        ovf       = 1'b0;
        if (flush) begin
            state_nxt = PREFIX;
            zcnt_nxt  = '0;
            rem_nxt   = '0;
            acc_nxt   = '0;
        end else if (accept) begin
            if (state == PREFIX) begin
                if (!bus.in_bit) begin
                    if (32'(zcnt) == max_prefix(DATA_W, 32'(k_eff))) begin
                        ovf      = 1'b1;
                        zcnt_nxt = '0;
                    end else begin
                        zcnt_nxt = zcnt + ZW'(1);
                    end
                end else begin
                    acc_nxt = AW'(1);
                    rem_nxt = zcnt + ZW'(k_eff);
                    if (rem_nxt == '0) begin
                        done     = 1'b1;
                        zcnt_nxt = '0;
                    end else begin
                        state_nxt = SUFFIX;
                    end
                end
            end else begin
                acc_nxt = {acc[AW-2:0], bus.in_bit};
                rem_nxt = rem - ZW'(1);
                if (rem_nxt == '0) begin
                    done      = 1'b1;
                    zcnt_nxt  = '0;
                    state_nxt = PREFIX;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state <= PREFIX;
            zcnt  <= '0;
            rem   <= '0;
            acc   <= '0;
            k_q   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            zcnt  <= zcnt_nxt;
            rem   <= rem_nxt;
            acc   <= acc_nxt;
            err   <= ovf;
            if (accept && first) k_q <= k_sel;
        end
    end

    // Output stage is fed from the next-state accumulator so the result lands one cycle after the last bit.
    assign one_k   = AW'(1) << k_eff;
    assign len_nxt = LW'({zcnt, 1'b0}) + LW'(k_eff) + LW'(1);

    gen_gamma_stream_decoder_sub #(.W(AW)) u_sub (
        .a (acc_nxt),
        .b (one_k),
        .y (diff)
    );

    gen_gamma_stream_decoder_reg #(.W(AW + LW)) u_payload (
        .clk   (clk),
        .res_n (res_n),
        .en    (done),
        .d     ({diff, len_nxt}),
        .q     (payload_q)
    );

    assign valid_nxt = done || (bus.out_valid && !bus.out_ready);

    gen_gamma_stream_decoder_reg #(.W(1)) u_valid (
        .clk   (clk),
        .res_n (res_n),
        .en    (1'b1),
        .d     (valid_nxt),
        .q     (bus.out_valid)
    );

    assign bus.out_data = payload_q[AW+LW-1:LW];
    assign bus.out_len  = payload_q[LW-1:0];

endmodule

// File: tb/tb_gen_gamma_stream_decoder.sv
// Scoreboard bench: codewords are built from random values, expected results queued, a monitor pops and compares.
module tb_gen_gamma_stream_decoder;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned K_MAX  = 3;
    localparam int unsigned KW     = $clog2(K_MAX + 1);
    localparam int unsigned LW     = $clog2(2 * DATA_W + 2);

    logic          clk = 1'b0;
    logic          res_n = 1'b0;
    logic          flush = 1'b0;
    logic [KW-1:0] k_sel = '0;
    logic          err;

    gen_gamma_stream_decoder_if #(.DATA_W(DATA_W), .LW(LW)) bus ();

    gen_gamma_stream_decoder #(.DATA_W(DATA_W), .K_MAX(K_MAX)) dut (
        .clk   (clk),
        .res_n (res_n),
        .flush (flush),
        .k_sel (k_sel),
        .bus   (bus),
        .err   (err)
    );

    always #5 clk = ~clk;

    int unsigned tests = 0, failed = 0;
    int unsigned exp_data[$], exp_len[$];
    int unsigned exp_err = 0, err_seen = 0;
    int unsigned rdy_mode = 1;   // 0 random, 1 always ready, 2 stalled
    bit          strict = 1'b0;

    function automatic void chk(input string name, input int unsigned act, input int unsigned exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Monitor: drives out_ready and checks every handshake against the scoreboard.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       bus.out_ready = ($urandom_range(0, 3) != 0);
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'b0;
            endcase
            #1;
            if (res_n) begin
                if (err) err_seen++;
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_data.size() == 0) begin
                        chk("unexpected output", 1, 0);
                    end else begin
                        chk("out_data", bus.out_data, exp_data.pop_front());
                        chk("out_len", bus.out_len, exp_len.pop_front());
                    end
                end else if (bus.out_valid) begin
                    chk("in_ready under backpressure", bus.in_ready, 0);
                end
            end
        end
    end

    task automatic send_bit(input logic b, input int unsigned k);
        int unsigned budget = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_bit   = b;
        k_sel        = KW'(k);
        #1;
        if (strict) chk("in_ready at full rate", bus.in_ready, 1);
        while (!bus.in_ready && budget < 200) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (!bus.in_ready) chk("in_ready timeout", 0, 1);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_cw(input int unsigned v, input int unsigned k);
        int unsigned x, n, z;
        bit fst = 1'b1;
        x = v + (32'd1 << k);
        n = 0;
        while ((x >> n) != 0) n++;
        z = n - 1 - k;
        exp_data.push_back(v);
        exp_len.push_back(n + z);
        for (int unsigned i = 0; i < z; i++) begin
            send_bit(1'b0, fst ? k : $urandom_range(0, K_MAX));
            fst = 1'b0;
        end
        for (int i = int'(n) - 1; i >= 0; i--) begin
            send_bit(x[i], fst ? k : $urandom_range(0, K_MAX));
            fst = 1'b0;
        end
        if (strict) fork
            begin
                @(negedge clk);
                #2;
                chk("latency out_valid", bus.out_valid, 1);
            end
        join_none
    endtask

    task automatic send_overflow(input int unsigned k);
        for (int unsigned i = 0; i < DATA_W - k + 1; i++)
            send_bit(1'b0, (i == 0) ? k : $urandom_range(0, K_MAX));
        exp_err++;
    endtask

    task automatic drain();
        int unsigned b = 0;
        while (exp_data.size() != 0 && b < 500) begin
            @(negedge clk);
            b++;
        end
        repeat (2) @(negedge clk);
        chk("drain leftover", exp_data.size(), 0);
    endtask

    task automatic flush_pulse();
        @(negedge clk);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_bit   = 1'b1;
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int unsigned k, v;
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
        #2;
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset out_data", bus.out_data, 0);
        chk("reset out_len", bus.out_len, 0);
        chk("reset err", err, 0);
        chk("reset in_ready", bus.in_ready, 1);
        repeat (2) @(negedge clk);
        res_n = 1'b1;

        // k=0 back-to-back at full rate
        strict = 1'b1;
        send_cw(0, 0);
        send_cw(1, 0);
        send_cw(6, 0);
        strict = 1'b0;
        idle();
        drain();

        // k=2 with k_sel wobbling after the first bit
        send_cw(0, 2);
        send_cw(7, 2);
        idle();
        drain();

        // widest codeword, then prefix overflow, then recovery
        send_cw(510, 0);
        idle();
        drain();
        send_overflow(0);
        fork
            begin
                @(negedge clk);
                #2;
                chk("err pulse", err, 1);
            end
        join_none
        send_cw(0, 0);
        idle();
        drain();

        // backpressure: pending output held, no bits lost
        rdy_mode = 2;
        send_cw(1, 0);
        fork
            send_cw(6, 0);
            begin
                repeat (4) begin
                    @(negedge clk);
                    #2;
                    chk("held out_valid", bus.out_valid, 1);
                    chk("held out_data", bus.out_data, 1);
                    chk("held in_ready", bus.in_ready, 0);
                end
                rdy_mode = 1;
            end
        join
        idle();
        drain();

        // flush mid-prefix, flush priority over a simultaneous bit
        send_bit(1'b0, 0);
        send_bit(1'b0, 0);
        flush_pulse();
        send_cw(0, 0);
        idle();
        drain();

        // pending output survives a flush
        rdy_mode = 2;
        send_cw(1, 0);
        idle();
        flush_pulse();
        #2;
        chk("flush keeps out_valid", bus.out_valid, 1);
        chk("flush keeps out_data", bus.out_data, 1);
        rdy_mode = 1;
        drain();

        // random traffic with random backpressure and overflows
        rdy_mode = 0;
        for (int unsigned n = 0; n < 60; n++) begin
            k = $urandom_range(0, K_MAX);
            if ($urandom_range(0, 7) == 0) begin
                send_overflow(k);
            end else begin
                v = $urandom_range(0, (32'd1 << (DATA_W + 1)) - (32'd1 << k) - 1);
                send_cw(v, k);
            end
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        rdy_mode = 1;
        drain();

        // asynchronous reset mid-suffix
        send_cw(6, 0);
        idle();
        drain();
        send_bit(1'b0, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        #3;
        res_n        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("async reset out_valid", bus.out_valid, 0);
        chk("async reset out_data", bus.out_data, 0);
        chk("async reset out_len", bus.out_len, 0);
        chk("async reset err", err, 0);
        @(negedge clk);
        res_n = 1'b1;
        send_cw(3, 1);
        send_cw(12, 3);
        idle();
        drain();

        repeat (3) @(negedge clk);
        chk("err pulse count", err_seen, exp_err);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
